// File: rtl/palette_pkg.sv
// ---------------------------------------------------------------------------
// palette_pkg
//   Shared types, constants and helpers for the palette encoder slice.
//   rgb_t   : packed RGB888 value {R[23:16], G[15:8], B[7:0]}
//   pidx_t  : 4-bit palette index
//   state_t : encoder FSM states
// ---------------------------------------------------------------------------
package palette_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [3:0]  pidx_t;

    localparam int    PAL_SIZE        = 16;
    localparam pidx_t TRANSPARENT_IDX = 4'd0;
    localparam int    DIST_W          = 10;

    typedef logic [DIST_W-1:0] dist_t;

    // Entry 0 is reserved for the transparent code, so a search only ever
    // walks entries 1..15.
    localparam pidx_t FIRST_SEARCH_IDX = 4'd1;
    localparam pidx_t LAST_SEARCH_IDX  = 4'd15;

    // Larger than any real L1 distance (max 3*255 = 765), so the first
    // evaluated entry always becomes the initial best.
    localparam dist_t DIST_INIT = 10'h3FF;

    localparam rgb_t BLACK_RGB = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Unsigned absolute difference of two 8-bit channels.
    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/rgb_l1_dist.sv
// ---------------------------------------------------------------------------
// rgb_l1_dist
//   Purely combinational Manhattan (L1) distance between two RGB888 colours.
//   i_a, i_b : colours to compare
//   o_dist   : |dR| + |dG| + |dB|, 10 bits wide so the worst case (765)
//              is represented without truncation
// ---------------------------------------------------------------------------
module rgb_l1_dist
    import palette_pkg::*;
(
    input  rgb_t              i_a,
    input  rgb_t              i_b,
    output logic [DIST_W-1:0] o_dist
);

    logic [7:0] d_r;
    logic [7:0] d_g;
    logic [7:0] d_b;

    assign d_r = abs_diff8(i_a[23:16], i_b[23:16]);
    assign d_g = abs_diff8(i_a[15:8],  i_b[15:8]);
    assign d_b = abs_diff8(i_a[7:0],   i_b[7:0]);

    // Each channel is zero-extended before summing so no carry is lost.
    assign o_dist = DIST_W'(d_r) + DIST_W'(d_g) + DIST_W'(d_b);

endmodule

// File: rtl/palette_encoder.sv
// ---------------------------------------------------------------------------
// palette_encoder
//   Maps an RGB888 pixel to the index of the nearest entry (L1 distance) in a
//   16-entry programmable palette. Entry 0 is the transparent code and is only
//   produced for a pure black pixel. A search walks entries 1..15, one per
//   clock, and exits early on an exact match.
//
//   i_clk        : clock, all state on the rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_pal_we     : palette write strobe (accepted in any state)
//   i_pal_addr   : palette entry to write
//   i_pal_data   : RGB888 value to write
//   i_pix_valid  : input pixel valid
//   o_pix_ready  : encoder idle and able to take a pixel
//   i_pix_rgb    : pixel to encode
//   o_idx_valid  : result index valid (held until i_idx_ready)
//   i_idx_ready  : downstream accepts the result
//   o_idx        : nearest palette index
//   o_busy       : a pixel is being searched or its result is pending
// ---------------------------------------------------------------------------
module palette_encoder
    import palette_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pal_we,
    input  logic [3:0]  i_pal_addr,
    input  logic [23:0] i_pal_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    input  logic [23:0] i_pix_rgb,
    output logic        o_idx_valid,
    input  logic        i_idx_ready,
    output logic [3:0]  o_idx,
    output logic        o_busy
);

    state_t state_q, state_d;
    rgb_t   pal_q [PAL_SIZE];
    rgb_t   pal_d [PAL_SIZE];
    rgb_t   pix_q, pix_d;
    pidx_t  k_q, k_d;
    pidx_t  best_idx_q, best_idx_d;
    dist_t  best_dist_q, best_dist_d;
    pidx_t  idx_q, idx_d;

    rgb_t   cur_entry;
    dist_t  cur_dist;

    // The search always compares the latched pixel against the registered
    // palette entry k, so a write lands in the search from the next cycle on.
    assign cur_entry = pal_q[k_q];

    rgb_l1_dist u_dist (
        .i_a    (pix_q),
        .i_b    (cur_entry),
        .o_dist (cur_dist)
    );

    // Next-state logic for the palette file, the search datapath and the FSM.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        k_d         = k_q;
        best_idx_d  = best_idx_q;
        best_dist_d = best_dist_q;
        idx_d       = idx_q;
        for (int i = 0; i < PAL_SIZE; i++) begin
            pal_d[i] = pal_q[i];
        end

        if (i_pal_we) begin
            pal_d[i_pal_addr] = i_pal_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_pix_valid) begin
                    pix_d = i_pix_rgb;
                    if (i_pix_rgb == BLACK_RGB) begin
                        // Black short-circuits to the transparent code.
                        idx_d   = TRANSPARENT_IDX;
                        state_d = ST_DONE;
                    end else begin
                        k_d         = FIRST_SEARCH_IDX;
                        best_idx_d  = FIRST_SEARCH_IDX;
                        best_dist_d = DIST_INIT;
                        state_d     = ST_SEARCH;
                    end
                end
            end

            ST_SEARCH: begin
                // Strict compare: on a tie the earlier (lower) index is kept.
                if (cur_dist < best_dist_q) begin
                    best_idx_d  = k_q;
                    best_dist_d = cur_dist;
                end

                if (cur_dist == '0) begin
                    idx_d   = k_q;
                    state_d = ST_DONE;
                end else if (k_q == LAST_SEARCH_IDX) begin
                    // best_idx_d already includes the verdict on entry 15.
                    idx_d   = best_idx_d;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end

            ST_DONE: begin
                if (i_idx_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset also wipes the palette and any in-flight pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            pix_q       <= '0;
            k_q         <= '0;
            best_idx_q  <= '0;
            best_dist_q <= '0;
            idx_q       <= '0;
            for (int i = 0; i < PAL_SIZE; i++) begin
                pal_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            k_q         <= k_d;
            best_idx_q  <= best_idx_d;
            best_dist_q <= best_dist_d;
            idx_q       <= idx_d;
            for (int i = 0; i < PAL_SIZE; i++) begin
                pal_q[i] <= pal_d[i];
            end
        end
    end

    assign o_pix_ready = (state_q == ST_IDLE);
    assign o_idx_valid = (state_q == ST_DONE);
    assign o_busy      = (state_q == ST_SEARCH) || (state_q == ST_DONE);
    assign o_idx       = idx_q;

endmodule

// File: tb/tb_palette_encoder.sv
// ---------------------------------------------------------------------------
// tb_palette_encoder
//   Directed bench for palette_encoder. The driver pushes the expected index
//   and latency of every accepted pixel into a queue; an independent monitor
//   pops and compares whenever the encoder presents a result.
// ---------------------------------------------------------------------------
module tb_palette_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_pal_we;
    logic [3:0]  i_pal_addr;
    logic [23:0] i_pal_data;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [23:0] i_pix_rgb;
    logic        o_idx_valid;
    logic        i_idx_ready;
    logic [3:0]  o_idx;
    logic        o_busy;

    typedef struct {
        logic [3:0] idx;
        int         lat;
        int         accept;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    palette_encoder dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pal_we    (i_pal_we),
        .i_pal_addr  (i_pal_addr),
        .i_pal_data  (i_pal_data),
        .i_pix_valid (i_pix_valid),
        .o_pix_ready (o_pix_ready),
        .i_pix_rgb   (i_pix_rgb),
        .o_idx_valid (o_idx_valid),
        .i_idx_ready (i_idx_ready),
        .o_idx       (o_idx),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Rising-edge counter used to measure accept-to-valid latency.
    always @(posedge i_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic writePal(input logic [3:0] addr, input logic [23:0] data);
        i_pal_we   = 1'b1;
        i_pal_addr = addr;
        i_pal_data = data;
        @(negedge i_clk);
        i_pal_we   = 1'b0;
    endtask

    // Offers a pixel once the encoder is ready; returns on the falling edge
    // right after the accepting rising edge.
    task automatic applyStimulus(input logic [23:0] rgb, input logic [3:0] exp_idx,
                                 input int exp_lat, input string name);
        exp_t e;
        int   budget = 0;
        while (!o_pix_ready && budget < 200) begin
            @(negedge i_clk);
            budget++;
        end
        if (!o_pix_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_ready_timeout: got 0, required 1", name);
            return;
        end
        i_pix_rgb   = rgb;
        i_pix_valid = 1'b1;
        e.idx    = exp_idx;
        e.lat    = exp_lat;
        e.accept = cycle + 1;
        e.name   = name;
        exp_q.push_back(e);
        @(negedge i_clk);
        i_pix_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int budget = 0;
        while ((exp_q.size() != 0 || !o_pix_ready) && budget < 200) begin
            @(negedge i_clk);
            budget++;
        end
        if (exp_q.size() != 0 || !o_pix_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_idle_timeout: pending %0d, required 0", name, exp_q.size());
        end
    endtask

    // Monitor: first cycle of each valid result is scored against the queue,
    // later cycles of the same result must hold the index steady.
    initial begin
        logic       seen;
        logic [3:0] held;
        exp_t       e;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                seen = 1'b0;
            end else if (o_idx_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_result: got idx %0h, required no result", o_idx);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput({e.name, "_idx"}, 32'(o_idx), 32'(e.idx));
                        checkOutput({e.name, "_latency"}, 32'(cycle - e.accept + 1), 32'(e.lat));
                    end
                    seen = 1'b1;
                    held = o_idx;
                end else begin
                    checkOutput("hold_idx", 32'(o_idx), 32'(held));
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_pal_we    = 1'b0;
        i_pal_addr  = '0;
        i_pal_data  = '0;
        i_pix_valid = 1'b0;
        i_pix_rgb   = '0;
        i_idx_ready = 1'b1;

        repeat (2) @(negedge i_clk);
        checkOutput("reset_idx_valid", 32'(o_idx_valid), 32'd0);
        checkOutput("reset_busy",      32'(o_busy),      32'd0);
        checkOutput("reset_idx",       32'(o_idx),       32'd0);
        checkOutput("reset_pix_ready", 32'(o_pix_ready), 32'd1);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checkOutput("post_reset_ready", 32'(o_pix_ready), 32'd1);

        // Palette: 1, 2, 15 programmed, everything else white.
        for (int a = 0; a < 16; a++) begin
            writePal(4'(a), 24'hFFFFFF);
        end
        writePal(4'd1,  24'h83E13E);
        writePal(4'd2,  24'hABBC36);
        writePal(4'd15, 24'hF2280E);

        // Exact match on the last entry: the whole walk runs.
        applyStimulus(24'hF2280E, 4'd15, 16, "match15");
        waitIdle("match15");

        // Exact match on entry 2: early exit.
        applyStimulus(24'hABBC36, 4'd2, 3, "match2");
        waitIdle("match2");

        // Black goes straight to the transparent code.
        applyStimulus(24'h000000, 4'd0, 1, "black");
        waitIdle("black");

        // Entries 1 and 3 are both at distance 2; lower index wins.
        writePal(4'd3, 24'h81DF3E);
        applyStimulus(24'h82E03E, 4'd1, 16, "tie");
        waitIdle("tie");

        // Nearest is entry 2 (distance 3). Entry 2 is overwritten after it
        // was evaluated, which must not change the answer.
        applyStimulus(24'hAABB35, 4'd2, 16, "late_write");
        repeat (2) @(negedge i_clk);
        writePal(4'd2, 24'hFFFFFF);
        waitIdle("late_write");
        writePal(4'd2, 24'hABBC36);

        // Downstream stalls for 5 cycles; a new pixel offered meanwhile is ignored.
        i_idx_ready = 1'b0;
        applyStimulus(24'hABBC36, 4'd2, 3, "stall");
        begin
            int budget = 0;
            while (!o_idx_valid && budget < 50) begin
                @(negedge i_clk);
                budget++;
            end
        end
        checkOutput("stall_valid_seen", 32'(o_idx_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            i_pix_rgb   = 24'h000000;
            i_pix_valid = 1'b1;
            @(negedge i_clk);
            checkOutput("stall_pix_ready", 32'(o_pix_ready), 32'd0);
            checkOutput("stall_idx_valid", 32'(o_idx_valid), 32'd1);
            checkOutput("stall_busy",      32'(o_busy),      32'd1);
        end
        i_pix_valid = 1'b0;
        i_idx_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("release_pix_ready", 32'(o_pix_ready), 32'd1);
        checkOutput("release_idx_valid", 32'(o_idx_valid), 32'd0);
        waitIdle("stall");

        // Reset in the middle of a search (k = 7).
        applyStimulus(24'h102030, 4'd15, 16, "aborted");
        repeat (6) @(negedge i_clk);
        checkOutput("pre_reset_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_idx_valid", 32'(o_idx_valid), 32'd0);
        checkOutput("mid_reset_busy",      32'(o_busy),      32'd0);
        checkOutput("mid_reset_pix_ready", 32'(o_pix_ready), 32'd1);
        checkOutput("mid_reset_idx",       32'(o_idx),       32'd0);
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checkOutput("after_reset_ready", 32'(o_pix_ready), 32'd1);
        checkOutput("after_reset_busy",  32'(o_busy),      32'd0);

        // With a cleared palette every entry is at distance 6 -> index 1.
        // The old palette would have produced index 15.
        applyStimulus(24'h010203, 4'd1, 16, "cleared_palette");
        waitIdle("cleared_palette");

        repeat (3) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_encoder.md
PALETTE_ENCODER -- requirements
Module: palette_encoder

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_pal_we, input, 1, palette entry write strobe.
REQ-004 SHALL have port i_pal_addr, input, 4, palette entry index to write.
REQ-005 SHALL have port i_pal_data, input, 24, RGB888 value to write ({R,G,B}).
REQ-006 SHALL have port i_pix_valid, input, 1, input pixel valid.
REQ-007 SHALL have port o_pix_ready, output, 1, encoder can accept a pixel.
REQ-008 SHALL have port i_pix_rgb, input, 24, RGB888 pixel to encode.
REQ-009 SHALL have port o_idx_valid, output, 1, result index valid.
REQ-010 SHALL have port i_idx_ready, input, 1, downstream accepts the index.
REQ-011 SHALL have port o_idx, output, 4, palette index nearest to the pixel.
REQ-012 SHALL have port o_busy, output, 1, high in SEARCH or DONE.

Function
REQ-013 SHALL hold a 16x24 palette register file; entry 0 is the transparent code.
- Write on i_pal_we at any state.
- New value is visible to the search from the next cycle.
REQ-014 SHALL implement FSM IDLE, SEARCH, DONE.
- o_pix_ready = (state==IDLE).
- o_idx_valid = (state==DONE).
REQ-015 SHALL, in IDLE when i_pix_valid&o_pix_ready, latch i_pix_rgb.
- Pixel 24'h000000: set o_idx=0 and go to DONE.
- Otherwise go to SEARCH with k=1, best_idx=1, best_dist=10'h3FF.
REQ-016 SHALL, in SEARCH, evaluate entry k each cycle.
- Distance: dist = |dR|+|dG|+|dB|, unsigned 10-bit (max 765), no truncation.
- Update best_idx and best_dist only when dist < best_dist; ties keep the lower index.
REQ-017 SHALL exit SEARCH to DONE when dist==0 (early exit, o_idx=k), or after k=15 (o_idx=best_idx).
- k SHALL never wrap to 0.
- Entry 0 is never searched for non-zero pixels.
REQ-018 SHALL set latency from the accept cycle to o_idx_valid as follows:
- 16 cycles for a full search.
- k+1 cycles for an exact match at entry k.
- 1 cycle for a black pixel.
REQ-019 SHALL hold o_idx and o_idx_valid stable in DONE until i_idx_ready.
- On handshake, return to IDLE; o_pix_ready rises the next cycle, so there is no same-cycle back-to-back accept.
REQ-020 SHALL ignore i_pix_valid outside IDLE.
- A palette write to an entry already evaluated in the current search SHALL NOT alter that search's result.

Reset
REQ-021 SHALL, while i_rst_n=0, asynchronously force:
- state=IDLE, o_idx=0, o_idx_valid=0, o_busy=0.
- All palette entries = 24'h000000.
- Latched pixel, k, best_idx, best_dist = 0.
REQ-022 SHALL assert o_pix_ready on the first clock edge after reset release.
- Reset mid-SEARCH or mid-DONE discards the pixel and the result; no stale o_idx_valid.

Structure
REQ-023 SHALL place in a shared palette_pkg:
- Types rgb_t (24-bit) and pidx_t (4-bit).
- Constants PAL_SIZE=16, TRANSPARENT_IDX=0, DIST_W=10.
- The FSM state enum.
REQ-024 SHALL instantiate one sub-module, rgb_l1_dist, which is combinational: two rgb_t in, 10-bit distance out.

Verification
REQ-025 SHALL load palette 1=24'h83E13E, 2=24'hABBC36, 15=24'hF2280E, others 24'hFFFFFF, then send 24'hF2280E.
- Required: o_idx=15, o_idx_valid 16 cycles after accept.
REQ-026 SHALL send 24'hABBC36 with the same palette.
- Required: exact match, o_idx=2, o_idx_valid 3 cycles after accept.
REQ-027 SHALL send 24'h000000.
- Required: o_idx=0 after 1 cycle.
REQ-028 SHALL send 24'h82E03E with entries 1=24'h83E13E and 3=24'h81DF3E (both dist 2).
- Required: tie resolves to o_idx=1.
REQ-029 SHALL hold i_idx_ready=0 for 5 cycles in DONE.
- Required: o_idx stable, o_pix_ready=0, i_pix_valid ignored.
- Release: IDLE next cycle.
REQ-030 SHALL assert i_rst_n=0 at search cycle 7.
- Required: immediately o_idx_valid=0, o_busy=0, palette cleared.
- After release, a new pixel completes normally.
